// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N:1 data multiplexer with manual select and a
// round-robin auto-scan over the channels enabled in ch_mask. Every output
// is registered. Each fresh sample comes with its channel index.
module mux_scan_reg #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned DWELL    = 1,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS-1:0]       ch_mask,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          ch_out,
    output logic                      valid,
    output logic                      wrap
);

    localparam int unsigned      CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    // Set by a wrap-around advance, reported with the first sample of the new sweep.
    logic             wrap_pend_q, wrap_pend_d;

    logic [WIDTH-1:0] dout_d;
    logic [SEL_W-1:0] ch_out_d;
    logic             valid_d, wrap_d;

    logic [WIDTH-1:0] sel_data, ptr_data;
    logic             sel_ok, ptr_on;
    logic [SEL_W-1:0] first_any, first_above, next_ptr;
    logic             any_on, above_on;

    // Channel decode: loop-based compares keep out-of-range selects at zero and
    // keep pointer arithmetic bounded by CHANNELS rather than 2^SEL_W.
    always_comb begin
        sel_data    = '0;
        sel_ok      = 1'b0;
        ptr_data    = '0;
        ptr_on      = 1'b0;
        first_any   = '0;
        any_on      = 1'b0;
        first_above = '0;
        above_on    = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (SEL_W'(i) == sel_in) begin
                sel_ok   = 1'b1;
                sel_data = din[i*WIDTH +: WIDTH];
            end
            if (SEL_W'(i) == ptr_q) begin
                ptr_on   = ch_mask[i];
                ptr_data = din[i*WIDTH +: WIDTH];
            end
            if (ch_mask[i] && !any_on) begin
                any_on    = 1'b1;
                first_any = SEL_W'(i);
            end
            if (ch_mask[i] && !above_on && (SEL_W'(i) > ptr_q)) begin
                above_on    = 1'b1;
                first_above = SEL_W'(i);
            end
        end
        next_ptr = above_on ? first_above : first_any;
    end

    // Next-state and output selection for manual, mode entry and auto-scan.
    always_comb begin
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        wrap_pend_d = wrap_pend_q;
        dout_d      = dout;
        ch_out_d    = ch_out;
        valid_d     = 1'b0;
        wrap_d      = 1'b0;
        if (en) begin
            mode_d = mode;
            if (!mode || !mode_q) begin
                // Manual, or the first auto cycle: reload the scan start point.
                ptr_d       = sel_ok ? sel_in : '0;
                cnt_d       = '0;
                wrap_pend_d = 1'b0;
                if (!mode) begin
                    dout_d   = sel_ok ? sel_data : '0;
                    ch_out_d = sel_in;
                    valid_d  = sel_ok;
                end
            end else if (any_on) begin
                if (ptr_on) begin
                    dout_d      = ptr_data;
                    ch_out_d    = ptr_q;
                    valid_d     = 1'b1;
                    wrap_d      = wrap_pend_q;
                    wrap_pend_d = 1'b0;
                end
                // Disabled channels are left immediately, without dwelling.
                if (!ptr_on || (cnt_q == CNT_LAST)) begin
                    ptr_d = next_ptr;
                    cnt_d = '0;
                    if (!above_on) begin
                        wrap_pend_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
            dout        <= '0;
            ch_out      <= '0;
            valid       <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            wrap_pend_q <= wrap_pend_d;
            dout        <= dout_d;
            ch_out      <= ch_out_d;
            valid       <= valid_d;
            wrap        <= wrap_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_reg.sv
// Testbench for mux_scan_reg: directed vectors. Expected samples are queued
// when stimulus is issued and checked by a monitor on every valid output.
module tb_mux_scan_reg;

    logic clk;
    logic rst;

    // 16-channel instance, DWELL=2
    logic         en16, mode16, valid16, wrap16;
    logic [3:0]   sel16, ch16;
    logic [15:0]  mask16;
    logic [127:0] din16;
    logic [7:0]   dout16;

    // 12-channel instance, DWELL=1
    logic         en12, mode12, valid12, wrap12;
    logic [3:0]   sel12, ch12;
    logic [11:0]  mask12;
    logic [95:0]  din12;
    logic [7:0]   dout12;

    // Expected {dout, ch_out, wrap}
    logic [12:0] q16[$];
    logic [12:0] q12[$];

    int n_pass  = 0;
    int n_total = 0;

    mux_scan_reg #(.WIDTH(8), .CHANNELS(16), .DWELL(2)) dut16 (
        .clk(clk), .rst(rst), .en(en16), .mode(mode16), .sel_in(sel16),
        .ch_mask(mask16), .din(din16), .dout(dout16), .ch_out(ch16),
        .valid(valid16), .wrap(wrap16)
    );

    mux_scan_reg #(.WIDTH(8), .CHANNELS(12), .DWELL(1)) dut12 (
        .clk(clk), .rst(rst), .en(en12), .mode(mode12), .sel_in(sel12),
        .ch_mask(mask12), .din(din12), .dout(dout12), .ch_out(ch12),
        .valid(valid12), .wrap(wrap12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor for the 16-channel instance
    always @(posedge clk) begin
        #1;
        if (valid16 === 1'b1) begin
            if (q16.size() == 0) begin
                n_total++;
                $display("FAIL dut16 unexpected sample: got ch=%0d dout=%0h, expected none",
                         ch16, dout16);
            end else begin
                chk("dut16 sample {dout,ch,wrap}", 32'({dout16, ch16, wrap16}),
                    32'(q16.pop_front()));
            end
        end else if (wrap16 !== 1'b0) begin
            n_total++;
            $display("FAIL dut16 wrap without valid: got %b, expected 0", wrap16);
        end
    end

    // Monitor for the 12-channel instance
    always @(posedge clk) begin
        #1;
        if (valid12 === 1'b1) begin
            if (q12.size() == 0) begin
                n_total++;
                $display("FAIL dut12 unexpected sample: got ch=%0d dout=%0h, expected none",
                         ch12, dout12);
            end else begin
                chk("dut12 sample {dout,ch,wrap}", 32'({dout12, ch12, wrap12}),
                    32'(q12.pop_front()));
            end
        end else if (wrap12 !== 1'b0) begin
            n_total++;
            $display("FAIL dut12 wrap without valid: got %b, expected 0", wrap12);
        end
    end

    initial begin
        rst = 1'b1;
        en16 = 1'b0; mode16 = 1'b0; sel16 = '0; mask16 = '0;
        en12 = 1'b0; mode12 = 1'b0; sel12 = '0; mask12 = '0;
        for (int i = 0; i < 16; i++) din16[i*8 +: 8] = 8'h10 + 8'(i);
        for (int i = 0; i < 12; i++) din12[i*8 +: 8] = 8'hA0 + 8'(i);
        repeat (2) step();

        // Reset state
        chk("reset dout16", 32'(dout16), 32'h0);
        chk("reset ch16", 32'(ch16), 32'h0);
        chk("reset valid16", 32'(valid16), 32'h0);
        chk("reset wrap16", 32'(wrap16), 32'h0);
        chk("reset dout12", 32'(dout12), 32'h0);
        chk("reset valid12", 32'(valid12), 32'h0);
        rst = 1'b0;
        step();

        // Manual select, one cycle latency
        en16 = 1'b1; sel16 = 4'd9;
        q16.push_back({8'h19, 4'd9, 1'b0});
        step();
        sel16 = 4'd3;
        q16.push_back({8'h13, 4'd3, 1'b0});
        step();
        en16 = 1'b0; sel16 = 4'd7;
        step();
        chk("en=0 valid16", 32'(valid16), 32'h0);
        chk("en=0 dout16 hold", 32'(dout16), 32'h13);
        chk("en=0 ch16 hold", 32'(ch16), 32'd3);

        // Auto scan over channels 0,2,5 with DWELL=2; entry cycle emits nothing
        en16 = 1'b1; mode16 = 1'b1; mask16 = 16'h0025; sel16 = 4'd0;
        step();
        chk("entry valid16", 32'(valid16), 32'h0);
        q16.push_back({8'h10, 4'd0, 1'b0});
        q16.push_back({8'h10, 4'd0, 1'b0});
        q16.push_back({8'h12, 4'd2, 1'b0});
        q16.push_back({8'h12, 4'd2, 1'b0});
        q16.push_back({8'h15, 4'd5, 1'b0});
        q16.push_back({8'h15, 4'd5, 1'b0});
        q16.push_back({8'h10, 4'd0, 1'b1});
        q16.push_back({8'h10, 4'd0, 1'b0});
        q16.push_back({8'h12, 4'd2, 1'b0});
        repeat (9) step();

        // Freeze mid-dwell on channel 2
        en16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("freeze valid16", 32'(valid16), 32'h0);
            chk("freeze ch16", 32'(ch16), 32'd2);
        end
        en16 = 1'b1;
        q16.push_back({8'h12, 4'd2, 1'b0});
        q16.push_back({8'h15, 4'd5, 1'b0});
        repeat (2) step();

        // Async reset mid-dwell on channel 5, observed before the next edge
        rst = 1'b1;
        #1;
        chk("async rst dout16", 32'(dout16), 32'h0);
        chk("async rst ch16", 32'(ch16), 32'h0);
        chk("async rst valid16", 32'(valid16), 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("post-rst entry valid16", 32'(valid16), 32'h0);
        q16.push_back({8'h10, 4'd0, 1'b0});
        q16.push_back({8'h10, 4'd0, 1'b0});
        q16.push_back({8'h12, 4'd2, 1'b0});
        repeat (3) step();

        // Empty mask: nothing emitted
        mask16 = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mask0 valid16", 32'(valid16), 32'h0);
            chk("mask0 wrap16", 32'(wrap16), 32'h0);
        end

        // Single channel 7: first cycle skips ptr=2, then wrap every DWELL cycles
        mask16 = 16'h0080;
        step();
        chk("skip valid16", 32'(valid16), 32'h0);
        q16.push_back({8'h17, 4'd7, 1'b0});
        q16.push_back({8'h17, 4'd7, 1'b0});
        q16.push_back({8'h17, 4'd7, 1'b1});
        q16.push_back({8'h17, 4'd7, 1'b0});
        q16.push_back({8'h17, 4'd7, 1'b1});
        q16.push_back({8'h17, 4'd7, 1'b0});
        repeat (6) step();
        en16 = 1'b0;

        // 12 channels: out-of-range manual select
        en12 = 1'b1; mode12 = 1'b0; sel12 = 4'd13;
        step();
        chk("oor13 valid12", 32'(valid12), 32'h0);
        chk("oor13 dout12", 32'(dout12), 32'h0);
        chk("oor13 ch12", 32'(ch12), 32'd13);
        sel12 = 4'd11;
        q12.push_back({8'hAB, 4'd11, 1'b0});
        step();
        sel12 = 4'd12;
        step();
        chk("oor12 valid12", 32'(valid12), 32'h0);
        chk("oor12 dout12", 32'(dout12), 32'h0);

        // Auto over channels 11 and 0: wraps modulo 12, not 16
        mode12 = 1'b1; mask12 = 12'h801; sel12 = 4'd11;
        step();
        chk("entry valid12", 32'(valid12), 32'h0);
        q12.push_back({8'hAB, 4'd11, 1'b0});
        q12.push_back({8'hA0, 4'd0, 1'b1});
        q12.push_back({8'hAB, 4'd11, 1'b0});
        q12.push_back({8'hA0, 4'd0, 1'b1});
        repeat (4) step();
        en12 = 1'b0;
        step();

        chk("q16 drained", 32'(q16.size()), 32'h0);
        chk("q12 drained", 32'(q12.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
